// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-outstanding memory port between ifetch (ibus) and data (dbus).
// Data wins by default; a starvation counter forces an ifetch grant after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [STRB_W-1:0] d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [STRB_W-1:0] m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    // state | meaning
    // IDLE  | no transaction; arbitrate between i_valid and d_valid
    // ADDR  | request presented downstream, waiting for m_addr_ok
    // DATA  | address accepted, waiting for m_data_ok
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ADDR = 3'b010,
        S_DATA = 3'b100
    } state_e;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;   // 1 = dbus owns the port
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             owner_valid;
    logic             ack_addr;
    logic             ack_data;

    assign owner_valid = owner_q ? d_valid : i_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        ack_addr  = 1'b0;
        ack_data  = 1'b0;
        m_valid   = 1'b0;
        m_addr    = '0;
        m_size    = 3'd0;
        m_strobe  = '0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (d_valid && !(i_valid && starve_q == CNT_MAX)) begin
                    owner_d = 1'b1;
                    state_d = S_ADDR;
                    if (i_valid) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (i_valid) begin
                    owner_d  = 1'b0;
                    state_d  = S_ADDR;
                    starve_d = '0;
                end
            end
            S_ADDR: begin
                if (!owner_valid) begin
                    // requester withdrew (flush) before the address was taken
                    state_d = S_IDLE;
                end else begin
                    m_valid  = 1'b1;
                    m_addr   = owner_q ? d_addr : i_addr;
                    m_size   = owner_q ? d_size : 3'd2;
                    m_strobe = owner_q ? d_strobe : '0;
                    m_wdata  = owner_q ? d_wdata : '0;
                    if (m_addr_ok) begin
                        ack_addr = 1'b1;
                        if (m_data_ok) begin
                            ack_data = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (m_data_ok) begin
                    ack_data = owner_valid;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        i_addr_ok = ack_addr && !owner_q;
        d_addr_ok = ack_addr && owner_q;
        i_data_ok = ack_data && !owner_q;
        d_data_ok = ack_data && owner_q;
        if (i_data_ok) begin
            i_rdata = m_rdata;
        end
        if (d_data_ok) begin
            d_rdata = m_rdata;
        end
    end

    a_state_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot(state_q));
    a_mvalid_addr:  assert property (@(posedge clk) disable iff (!reset) m_valid |-> state_q == S_ADDR);
    a_one_data_ok:  assert property (@(posedge clk) disable iff (!reset) !(i_data_ok && d_data_ok));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected downstream requests and responses are queued
// by the stimulus thread and popped by a negedge monitor as the DUT presents them.
module tb_mem_port_arbiter;

    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [63:0] i_rdata;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [63:0] m_rdata;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] wdata;
        int          cyc;
    } m_exp_t;

    typedef struct {
        bit          is_d;
        logic [63:0] rdata;
        int          cyc;
    } r_exp_t;

    m_exp_t mq[$];
    r_exp_t rq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_m(input bit is_d, input logic [63:0] addr, input logic [2:0] sz,
                          input logic [7:0] strb, input logic [63:0] wd, input int c);
        m_exp_t e;
        e.is_d = is_d; e.addr = addr; e.size = sz; e.strb = strb; e.wdata = wd; e.cyc = c;
        mq.push_back(e);
    endtask

    task automatic push_r(input bit is_d, input logic [63:0] rd, input int c);
        r_exp_t e;
        e.is_d = is_d; e.rdata = rd; e.cyc = c;
        rq.push_back(e);
    endtask

    // Monitor: every cycle while out of reset
    always @(negedge clk) begin
        if (reset) begin
            if (m_valid && m_addr_ok) begin
                if (mq.size() == 0) begin
                    check("unexpected_addr_accept", 1, 0);
                end else begin
                    m_exp_t e;
                    e = mq.pop_front();
                    check("m_addr", m_addr, e.addr);
                    check("m_size", {61'd0, m_size}, {61'd0, e.size});
                    check("m_strobe", {56'd0, m_strobe}, {56'd0, e.strb});
                    check("m_wdata", m_wdata, e.wdata);
                    check("addr_ok_owner", {62'd0, i_addr_ok, d_addr_ok}, {62'd0, !e.is_d, e.is_d});
                    if (e.cyc >= 0) check("addr_ok_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("stray_addr_ok", {62'd0, i_addr_ok, d_addr_ok}, 64'd0);
            end
            if (i_data_ok || d_data_ok) begin
                if (rq.size() == 0) begin
                    check("unexpected_data_ok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
                end else begin
                    r_exp_t r;
                    r = rq.pop_front();
                    check("data_ok_owner", {62'd0, i_data_ok, d_data_ok}, {62'd0, !r.is_d, r.is_d});
                    check("rdata", r.is_d ? d_rdata : i_rdata, r.rdata);
                    if (r.cyc >= 0) check("data_ok_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (!i_data_ok) check("i_rdata_idle", i_rdata, 64'd0);
            if (!d_data_ok) check("d_rdata_idle", d_rdata, 64'd0);
        end
    end

    task automatic wait_mvalid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        check("m_valid_timeout", 0, 1);
    endtask

    // Downstream model: accept address alat cycles into ADDR, return data dlat cycles later
    task automatic serve(input int alat, input int dlat, input logic [63:0] rd);
        bit ok;
        wait_mvalid(ok);
        if (!ok) return;
        repeat (alat) tick();
        m_addr_ok = 1'b1;
        if (dlat == 0) begin
            m_data_ok = 1'b1;
            m_rdata   = rd;
        end
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = JUNK;
        if (dlat > 0) begin
            repeat (dlat - 1) tick();
            m_data_ok = 1'b1;
            m_rdata   = rd;
            tick();
            m_data_ok = 1'b0;
            m_rdata   = JUNK;
        end
    endtask

    // Single transaction issued from IDLE: grant now, ADDR next cycle, so all cycles are known
    task automatic txn(input bit is_d, input logic [63:0] addr, input logic [7:0] strb,
                       input logic [63:0] wd, input logic [2:0] sz, input logic [63:0] rd,
                       input int alat, input int dlat);
        int a;
        a = cyc + 1 + alat;
        if (is_d) begin
            push_m(1'b1, addr, sz, strb, wd, a);
            d_valid = 1'b1; d_addr = addr; d_strobe = strb; d_wdata = wd; d_size = sz;
        end else begin
            push_m(1'b0, addr, 3'd2, 8'd0, 64'd0, a);
            i_valid = 1'b1; i_addr = addr;
        end
        push_r(is_d, rd, a + dlat);
        serve(alat, dlat, rd);
        if (is_d) d_valid = 1'b0;
        else      i_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        check({name, "_m_addr"}, m_addr, 64'd0);
        check({name, "_oks"}, {60'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 64'd0);
        check({name, "_rdata"}, i_rdata | d_rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b0;
        i_valid = 1'b0; i_addr = 64'h0;
        d_valid = 1'b0; d_addr = 64'h0; d_size = 3'd0; d_strobe = 8'h0; d_wdata = 64'h0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = JUNK;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // T1: lone ifetch, addr_ok after one wait cycle, data two cycles later
        txn(1'b0, 64'h8000_0000, 8'h00, 64'h0, 3'd0, 64'h13, 1, 2);
        tick();

        // T2: simultaneous requests, dbus store first, ifetch in the following IDLE
        begin
            int base;
            base = cyc;
            i_valid = 1'b1; i_addr = 64'h8000_0100;
            d_valid = 1'b1; d_addr = 64'h8000_1000; d_strobe = 8'hFF;
            d_wdata = 64'h1122_3344_5566_7788; d_size = 3'd3;
            push_m(1'b1, 64'h8000_1000, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, base + 1);
            push_r(1'b1, 64'h0, base + 2);
            push_m(1'b0, 64'h8000_0100, 3'd2, 8'h00, 64'h0, base + 4);
            push_r(1'b0, 64'h0000_0000_ABCD_0001, base + 5);
            serve(0, 1, 64'h0);
            d_valid = 1'b0;
            serve(0, 1, 64'h0000_0000_ABCD_0001);
            i_valid = 1'b0;
        end
        tick();

        // T3: both held; expect D D D D I D D D D I
        i_valid = 1'b1; i_addr = 64'h8000_0200;
        d_valid = 1'b1; d_addr = 64'h8000_3000; d_strobe = 8'h00; d_wdata = 64'h0; d_size = 3'd2;
        for (int t = 0; t < 10; t++) begin
            bit is_i;
            is_i = (t == 4) || (t == 9);
            if (is_i) push_m(1'b0, 64'h8000_0200, 3'd2, 8'h00, 64'h0, -1);
            else      push_m(1'b1, 64'h8000_3000, 3'd2, 8'h00, 64'h0, -1);
            push_r(!is_i, 64'h100 + 64'(t), -1);
        end
        for (int t = 0; t < 10; t++) serve(0, 1, 64'h100 + 64'(t));
        i_valid = 1'b0; d_valid = 1'b0;
        tick();

        // T4a: fetch cancelled in ADDR
        i_valid = 1'b1; i_addr = 64'h8000_0040;
        tick();
        check("t4a_mvalid_in_addr", {63'd0, m_valid}, 64'd1);
        i_valid = 1'b0;
        #1;
        check("t4a_mvalid_dropped", {63'd0, m_valid}, 64'd0);
        tick();
        txn(1'b1, 64'h8000_4000, 8'h00, 64'h0, 3'd3, 64'h4444, 0, 1);
        tick();

        // T4b: fetch cancelled in DATA, response swallowed
        i_valid = 1'b1; i_addr = 64'h8000_0080;
        push_m(1'b0, 64'h8000_0080, 3'd2, 8'h00, 64'h0, -1);
        wait_mvalid(ok);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        i_valid = 1'b0;
        tick();
        m_data_ok = 1'b1; m_rdata = 64'h77;
        tick();
        m_data_ok = 1'b0; m_rdata = JUNK;
        txn(1'b1, 64'h8000_5000, 8'h0F, 64'h5555, 3'd2, 64'h5A5A, 1, 1);
        tick();

        // T5: reset asserted while in DATA, late response ignored
        d_valid = 1'b1; d_addr = 64'h0000_0100; d_strobe = 8'h00; d_wdata = 64'h0; d_size = 3'd3;
        push_m(1'b1, 64'h0000_0100, 3'd3, 8'h00, 64'h0, -1);
        wait_mvalid(ok);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        reset = 1'b0; d_valid = 1'b0;
        #1;
        check_all_zero("t5_in_reset");
        tick();
        reset = 1'b1;
        m_data_ok = 1'b1; m_rdata = 64'h55;
        #1;
        check("t5_late_data_ok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
        tick();
        m_data_ok = 1'b0; m_rdata = JUNK;
        txn(1'b1, 64'h0000_0200, 8'h00, 64'h0, 3'd3, 64'h99, 2, 3);
        tick();

        // T6: address and data accepted in the same ADDR cycle
        txn(1'b1, 64'h8000_2000, 8'h0F, 64'hCAFE, 3'd2, 64'hBEEF, 0, 0);
        #1;
        check("t6_idle_after", {63'd0, m_valid}, 64'd0);
        repeat (3) tick();

        check("m_queue_drained", 64'(mq.size()), 64'd0);
        check("r_queue_drained", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
